// File: rtl/rv32_types_pkg.sv
// Shared RV32 core types: memory operation encoding and helpers used by the
// MEM stage and the writeback load-fix logic.
package rv32_types;

  localparam int XLEN = 32;

  typedef enum logic [3:0] {
    MEM_NOP = 4'd0,
    MEM_LB,
    MEM_LH,
    MEM_LW,
    MEM_LBU,
    MEM_LHU,
    MEM_SB,
    MEM_SH,
    MEM_SW
  } mem_op_t;

  function automatic logic mem_is_load(input mem_op_t op);
    return op inside {MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU};
  endfunction

  function automatic logic mem_is_store(input mem_op_t op);
    return op inside {MEM_SB, MEM_SH, MEM_SW};
  endfunction

  // Word accesses need addr[1:0]==0, halfword accesses need addr[0]==0.
  function automatic logic mem_misaligned(input mem_op_t op, input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    case (op)
      MEM_LW, MEM_SW:          mis = (addr_lo != 2'b00);
      MEM_LH, MEM_LHU, MEM_SH: mis = addr_lo[0];
      default:                 mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/rv32_dmem_ctrl_store_align.sv
// Store lane alignment: byte enables and lane-replicated write data for one
// access, so any byte/halfword lane the enables select carries the store value.
module rv32_store_align
  import rv32_types::*;
(
  input  mem_op_t     op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_lane
);

  // Select enables by access width; loads read the whole word
  always_comb begin
    be         = 4'b0000;
    wdata_lane = 32'h0;
    case (op)
      MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU: begin
        be = 4'b1111;
      end
      MEM_SW: begin
        be         = 4'b1111;
        wdata_lane = wdata;
      end
      MEM_SH: begin
        be         = 4'b0011 << addr_lo;
        wdata_lane = {2{wdata[15:0]}};
      end
      MEM_SB: begin
        be         = 4'b0001 << addr_lo;
        wdata_lane = {4{wdata[7:0]}};
      end
      default: begin
        be         = 4'b0000;
        wdata_lane = 32'h0;
      end
    endcase
  end

endmodule

// File: rtl/rv32_dmem_ctrl.sv
// MEM-stage data-memory controller. Runs one load/store at a time over a
// req/gnt + rvalid bus, stalls the pipeline until the response returns and
// hands the raw word plus op/address to the writeback load-fix logic.
module rv32_dmem_ctrl
  import rv32_types::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  mem_op_t     req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        flush,
  output logic        stall,
  output logic        done,
  output logic        fault_misaligned,
  output logic        fault_bus,
  output mem_op_t     wb_op,
  output logic [31:0] wb_addr,
  output logic [31:0] wb_raw_load,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic        mem_err
);

  localparam int TO_LIMIT = (TIMEOUT_CYCLES < 1) ? 1 : TIMEOUT_CYCLES;
  localparam int CNT_W    = $clog2(TO_LIMIT + 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_LIMIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [31:0]       mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  mem_op_t           wb_op_q, wb_op_d;
  logic [31:0]       wb_addr_q, wb_addr_d;
  logic [31:0]       wb_raw_q, wb_raw_d;
  logic              fault_q, fault_d;

  logic              is_access;
  logic              misaligned;
  logic              in_idle;
  logic              accept;
  logic              timeout;
  logic [3:0]        be_w;
  logic [31:0]       wdata_w;

  rv32_store_align u_store_align (
    .op         (req_op),
    .addr_lo    (req_addr[1:0]),
    .wdata      (req_wdata),
    .be         (be_w),
    .wdata_lane (wdata_w)
  );

  // Acceptance decode; rst blocks new work so outputs stay quiet while held
  always_comb begin
    is_access        = req_valid && (req_op != MEM_NOP);
    misaligned       = mem_misaligned(req_op, req_addr[1:0]);
    in_idle          = (state_q == S_IDLE);
    accept           = in_idle && is_access && !misaligned && !flush && !rst;
    fault_misaligned = in_idle && is_access &&  misaligned && !flush && !rst;
    timeout          = (cnt_q == TO_LAST);
  end

  // Pipeline-facing status; a flush in DONE suppresses completion reporting
  always_comb begin
    stall     = accept || (state_q == S_REQ) || (state_q == S_WAIT) || (state_q == S_DRAIN);
    done      = (state_q == S_DONE) && !flush;
    fault_bus = (state_q == S_DONE) && fault_q && !flush;
  end

  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_be      = mem_be_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign wb_op       = wb_op_q;
  assign wb_addr     = wb_addr_q;
  assign wb_raw_load = wb_raw_q;

  // Next-state and next-register values for the access sequencer
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    wb_op_d     = wb_op_q;
    wb_addr_d   = wb_addr_q;
    wb_raw_d    = wb_raw_q;
    fault_d     = fault_q;

    case (state_q)
      S_IDLE: begin
        // A late rvalid from a timed-out access lands here and is dropped.
        if (accept) begin
          state_d     = S_REQ;
          cnt_d       = '0;
          mem_req_d   = 1'b1;
          mem_we_d    = mem_is_store(req_op);
          mem_be_d    = be_w;
          mem_addr_d  = {req_addr[31:2], 2'b00};
          mem_wdata_d = wdata_w;
          wb_op_d     = req_op;
          wb_addr_d   = req_addr;
          fault_d     = 1'b0;
        end
      end

      S_REQ: begin
        // rvalid is not expected before gnt and is ignored here.
        if (flush) begin
          // If the grant coincides with the flush the slave still owes a response.
          mem_req_d = 1'b0;
          state_d   = mem_gnt ? S_DRAIN : S_IDLE;
        end else if (timeout) begin
          mem_req_d = 1'b0;
          wb_raw_d  = 32'h0;
          fault_d   = 1'b1;
          state_d   = S_DONE;
        end else if (mem_gnt) begin
          mem_req_d = 1'b0;
          cnt_d     = cnt_q + CNT_W'(1);
          state_d   = S_WAIT;
        end else begin
          cnt_d     = cnt_q + CNT_W'(1);
        end
      end

      S_WAIT: begin
        if (mem_rvalid) begin
          // A response arriving with a flush is consumed silently.
          wb_raw_d = mem_rdata;
          fault_d  = mem_err;
          state_d  = flush ? S_IDLE : S_DONE;
        end else if (flush) begin
          state_d  = S_DRAIN;
        end else if (timeout) begin
          wb_raw_d = 32'h0;
          fault_d  = 1'b1;
          state_d  = S_DONE;
        end else begin
          cnt_d    = cnt_q + CNT_W'(1);
        end
      end

      S_DRAIN: begin
        if (mem_rvalid) begin
          state_d = S_IDLE;
        end
      end

      S_DONE: begin
        // The instruction is still presented this cycle; never re-accept it.
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Register all sequencer state and bus/writeback outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= 4'b0000;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      wb_op_q     <= MEM_NOP;
      wb_addr_q   <= 32'h0;
      wb_raw_q    <= 32'h0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      wb_op_q     <= wb_op_d;
      wb_addr_q   <= wb_addr_d;
      wb_raw_q    <= wb_raw_d;
      fault_q     <= fault_d;
    end
  end

endmodule

// File: tb/tb_rv32_dmem_ctrl.sv
// Bench for rv32_dmem_ctrl: directed vector table, hand-written multi-cycle
// sequences (stall-hold, flush/drain, timeout, reset mid-access) and random
// accesses checked against a byte-level reference model.
module tb_rv32_dmem_ctrl;
  import rv32_types::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  mem_op_t     req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        flush;
  logic        mem_gnt, mem_rvalid, mem_err;
  logic [31:0] mem_rdata;

  logic        stall, done, fault_misaligned, fault_bus;
  mem_op_t     wb_op;
  logic [31:0] wb_addr, wb_raw_load;
  logic        mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata;

  // second instance with a short timeout, own bus side
  logic        t_gnt, t_rvalid, t_err;
  logic [31:0] t_rdata;
  logic        t_stall, t_done, t_fault_misaligned, t_fault_bus;
  mem_op_t     t_wb_op;
  logic [31:0] t_wb_addr, t_wb_raw_load;
  logic        t_mem_req, t_mem_we;
  logic [3:0]  t_mem_be;
  logic [31:0] t_mem_addr, t_mem_wdata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rv32_dmem_ctrl #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .flush(flush),
    .stall(stall), .done(done), .fault_misaligned(fault_misaligned),
    .fault_bus(fault_bus), .wb_op(wb_op), .wb_addr(wb_addr),
    .wb_raw_load(wb_raw_load), .mem_req(mem_req), .mem_we(mem_we),
    .mem_be(mem_be), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .mem_err(mem_err)
  );

  rv32_dmem_ctrl #(.TIMEOUT_CYCLES(4)) dut_t (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .flush(flush),
    .stall(t_stall), .done(t_done), .fault_misaligned(t_fault_misaligned),
    .fault_bus(t_fault_bus), .wb_op(t_wb_op), .wb_addr(t_wb_addr),
    .wb_raw_load(t_wb_raw_load), .mem_req(t_mem_req), .mem_we(t_mem_we),
    .mem_be(t_mem_be), .mem_addr(t_mem_addr), .mem_wdata(t_mem_wdata),
    .mem_gnt(t_gnt), .mem_rvalid(t_rvalid), .mem_rdata(t_rdata),
    .mem_err(t_err)
  );

  typedef struct {
    mem_op_t     op;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          gd;
    int          rd;
    logic [31:0] rdata;
    logic        err;
    logic [3:0]  be;
    logic [31:0] wd;
    logic        mis;
  } vec_t;

  vec_t vecs[14];

  // ---------------- reference model (byte-level view) ----------------
  function automatic int m_size(input mem_op_t op);
    case (op)
      MEM_LB, MEM_LBU, MEM_SB: return 1;
      MEM_LH, MEM_LHU, MEM_SH: return 2;
      MEM_LW, MEM_SW:          return 4;
      default:                 return 0;
    endcase
  endfunction

  function automatic bit m_store(input mem_op_t op);
    return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
  endfunction

  function automatic bit m_mis(input mem_op_t op, input logic [31:0] addr);
    int sz;
    sz = m_size(op);
    return (sz > 0) && ((addr % sz) != 0);
  endfunction

  function automatic logic [3:0] m_be(input mem_op_t op, input logic [31:0] addr);
    int sz;
    int lanes;
    sz = m_size(op);
    if (sz == 0) return 4'h0;
    if (!m_store(op)) return 4'hF;
    lanes = ((1 << sz) - 1) << (addr % 4);
    return 4'(lanes);
  endfunction

  function automatic logic [31:0] m_wd(input mem_op_t op, input logic [31:0] wd);
    if (!m_store(op)) return 32'h0;
    case (m_size(op))
      1:       return (wd & 32'hFF) * 32'h0101_0101;
      2:       return (wd & 32'hFFFF) * 32'h0001_0001;
      default: return wd;
    endcase
  endfunction

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = 1'b0; req_op = MEM_NOP; req_addr = 32'h0; req_wdata = 32'h0;
    flush = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0; mem_err = 1'b0;
    t_gnt = 1'b0; t_rvalid = 1'b0; t_rdata = 32'h0; t_err = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_stall"}, 32'(stall), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_fault_mis"}, 32'(fault_misaligned), 0);
    chk({tag, "_fault_bus"}, 32'(fault_bus), 0);
    chk({tag, "_wb_op"}, 32'(wb_op), 32'(MEM_NOP));
    chk({tag, "_wb_addr"}, wb_addr, 0);
    chk({tag, "_wb_raw"}, wb_raw_load, 0);
    chk({tag, "_mem_req"}, 32'(mem_req), 0);
    chk({tag, "_mem_we"}, 32'(mem_we), 0);
    chk({tag, "_mem_be"}, 32'(mem_be), 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
  endtask

  // One complete access on the main instance: gnt in REQ cycle gd, rvalid in WAIT cycle rd.
  task automatic run_access(input mem_op_t op, input logic [31:0] addr, input logic [31:0] wdata,
                            input int gd, input int rd, input logic [31:0] rdata, input logic err,
                            input logic [3:0] ebe, input logic [31:0] ewd, input logic emis);
    bit acc;
    acc = (op != MEM_NOP) && !emis;
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata;
    @(negedge clk);
    chk("accept_stall", 32'(stall), 32'(acc));
    chk("fault_misaligned", 32'(fault_misaligned), 32'(emis));
    chk("accept_done", 32'(done), 0);
    next_cycle();
    if (acc) begin
      for (int i = 0; i <= gd; i++) begin
        mem_gnt = (i == gd);
        @(negedge clk);
        chk("req_mem_req", 32'(mem_req), 1);
        chk("req_mem_we", 32'(mem_we), 32'(m_store(op)));
        chk("req_mem_be", 32'(mem_be), 32'(ebe));
        chk("req_mem_addr", mem_addr, addr & 32'hFFFF_FFFC);
        chk("req_mem_wdata", mem_wdata, ewd);
        chk("req_stall", 32'(stall), 1);
        chk("req_done", 32'(done), 0);
        next_cycle();
      end
      mem_gnt = 1'b0;
      mem_rdata = rdata;
      mem_err = err;
      for (int j = 0; j <= rd; j++) begin
        mem_rvalid = (j == rd);
        @(negedge clk);
        chk("wait_mem_req", 32'(mem_req), 0);
        chk("wait_stall", 32'(stall), 1);
        chk("wait_done", 32'(done), 0);
        next_cycle();
      end
      mem_rvalid = 1'b0; mem_err = 1'b0;
      @(negedge clk);
      chk("done_pulse", 32'(done), 1);
      chk("done_stall", 32'(stall), 0);
      chk("done_fault_bus", 32'(fault_bus), 32'(err));
      chk("done_wb_raw", wb_raw_load, rdata);
      chk("done_wb_op", 32'(wb_op), 32'(op));
      chk("done_wb_addr", wb_addr, addr);
      next_cycle();
    end
    req_valid = 1'b0; req_op = MEM_NOP;
    @(negedge clk);
    chk("gap_stall", 32'(stall), 0);
    chk("gap_mem_req", 32'(mem_req), 0);
    chk("gap_done", 32'(done), 0);
    chk("gap_fault_bus", 32'(fault_bus), 0);
    next_cycle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //             op       addr          wdata         gd rd rdata         err be    wd            mis
    vecs[0]  = '{MEM_LW,  32'h0000_0100, 32'h0,        0, 0, 32'hDEAD_BEEF, 0, 4'hF, 32'h0,        0};
    vecs[1]  = '{MEM_SB,  32'h0000_0203, 32'h0000_00A5, 1, 0, 32'h0,        0, 4'h8, 32'hA5A5_A5A5, 0};
    vecs[2]  = '{MEM_LH,  32'h0000_0101, 32'h0,        0, 0, 32'h0,        0, 4'h0, 32'h0,        1};
    vecs[3]  = '{MEM_SH,  32'h0000_0302, 32'h1234_ABCD, 0, 1, 32'h0,        0, 4'hC, 32'hABCD_ABCD, 0};
    vecs[4]  = '{MEM_SW,  32'h0000_0404, 32'h1234_5678, 2, 0, 32'h0,        0, 4'hF, 32'h1234_5678, 0};
    vecs[5]  = '{MEM_LBU, 32'h0000_0007, 32'h0,        2, 1, 32'h1122_3344, 0, 4'hF, 32'h0,        0};
    vecs[6]  = '{MEM_LW,  32'h0000_0500, 32'h0,        0, 0, 32'hCAFE_F00D, 1, 4'hF, 32'h0,        0};
    vecs[7]  = '{MEM_SW,  32'h0000_0102, 32'h5555_5555, 0, 0, 32'h0,        0, 4'h0, 32'h0,        1};
    vecs[8]  = '{MEM_NOP, 32'h0000_0003, 32'h0,        0, 0, 32'h0,        0, 4'h0, 32'h0,        0};
    vecs[9]  = '{MEM_SB,  32'h0000_0200, 32'h0000_FF5A, 0, 0, 32'h0,        0, 4'h1, 32'h5A5A_5A5A, 0};
    vecs[10] = '{MEM_SH,  32'h0000_0300, 32'h0000_BEEF, 1, 1, 32'h0,        1, 4'h3, 32'hBEEF_BEEF, 0};
    vecs[11] = '{MEM_LHU, 32'h0000_00FE, 32'h0,        1, 2, 32'h8000_0001, 0, 4'hF, 32'h0,        0};
    vecs[12] = '{MEM_LH,  32'h0000_0103, 32'h0,        0, 0, 32'h0,        0, 4'h0, 32'h0,        1};
    vecs[13] = '{MEM_LB,  32'h0000_0003, 32'h0,        3, 3, 32'h0F0F_0F0F, 0, 4'hF, 32'h0,        0};

    rst = 1'b1;
    idle_inputs();
    next_cycle();
    @(negedge clk);
    chk_all_zero("reset");
    next_cycle();
    rst = 1'b0;
    next_cycle();

    // directed table
    for (int v = 0; v < 14; v++) begin
      run_access(vecs[v].op, vecs[v].addr, vecs[v].wdata, vecs[v].gd, vecs[v].rd,
                 vecs[v].rdata, vecs[v].err, vecs[v].be, vecs[v].wd, vecs[v].mis);
    end

    // gnt withheld 3 cycles: request held stable; flush in WAIT drains the response
    req_valid = 1'b1; req_op = MEM_SW; req_addr = 32'h0000_0040; req_wdata = 32'h1122_3344;
    @(negedge clk);
    chk("hold_accept_stall", 32'(stall), 1);
    next_cycle();
    for (int i = 0; i < 4; i++) begin
      mem_gnt = (i == 3);
      @(negedge clk);
      chk("hold_mem_req", 32'(mem_req), 1);
      chk("hold_mem_addr", mem_addr, 32'h0000_0040);
      chk("hold_mem_be", 32'(mem_be), 32'hF);
      chk("hold_mem_wdata", mem_wdata, 32'h1122_3344);
      next_cycle();
    end
    mem_gnt = 1'b0; flush = 1'b1;
    @(negedge clk);
    chk("flush_wait_stall", 32'(stall), 1);
    chk("flush_wait_done", 32'(done), 0);
    next_cycle();
    flush = 1'b0; req_valid = 1'b0; req_op = MEM_NOP;
    for (int k = 0; k < 3; k++) begin
      mem_rvalid = (k == 2); mem_rdata = 32'h0000_0099;
      @(negedge clk);
      chk("drain_stall", 32'(stall), 1);
      chk("drain_done", 32'(done), 0);
      chk("drain_mem_req", 32'(mem_req), 0);
      next_cycle();
    end
    mem_rvalid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("post_drain_done", 32'(done), 0);
      chk("post_drain_stall", 32'(stall), 0);
      chk("post_drain_fault_bus", 32'(fault_bus), 0);
      next_cycle();
    end

    // flush in REQ before gnt: request withdrawn next cycle
    req_valid = 1'b1; req_op = MEM_LW; req_addr = 32'h0000_0080;
    next_cycle();
    flush = 1'b1;
    @(negedge clk);
    chk("flush_req_mem_req", 32'(mem_req), 1);
    next_cycle();
    flush = 1'b0; req_valid = 1'b0; req_op = MEM_NOP;
    @(negedge clk);
    chk("flush_req_dropped", 32'(mem_req), 0);
    chk("flush_req_stall", 32'(stall), 0);
    chk("flush_req_done", 32'(done), 0);
    next_cycle();

    // timeout instance: one good access, then a timed-out one, then a late rvalid
    do_reset();
    req_valid = 1'b1; req_op = MEM_LW; req_addr = 32'h0000_0010;
    next_cycle();
    t_gnt = 1'b1;
    next_cycle();
    t_gnt = 1'b0; t_rvalid = 1'b1; t_rdata = 32'h5555_AAAA;
    next_cycle();
    t_rvalid = 1'b0;
    @(negedge clk);
    chk("t_good_done", 32'(t_done), 1);
    chk("t_good_raw", t_wb_raw_load, 32'h5555_AAAA);
    next_cycle();
    req_valid = 1'b0;
    next_cycle();
    req_valid = 1'b1; req_op = MEM_LW; req_addr = 32'h0000_0014;
    @(negedge clk);
    chk("t_accept_stall", 32'(t_stall), 1);
    next_cycle();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t_req_mem_req", 32'(t_mem_req), 1);
      chk("t_req_done", 32'(t_done), 0);
      next_cycle();
    end
    @(negedge clk);
    chk("t_timeout_done", 32'(t_done), 1);
    chk("t_timeout_fault", 32'(t_fault_bus), 1);
    chk("t_timeout_raw", t_wb_raw_load, 0);
    chk("t_timeout_mem_req", 32'(t_mem_req), 0);
    chk("t_timeout_stall", 32'(t_stall), 0);
    next_cycle();
    req_valid = 1'b0; req_op = MEM_NOP;
    t_rvalid = 1'b1; t_rdata = 32'h7777_7777; t_err = 1'b1;
    @(negedge clk);
    chk("t_late_done", 32'(t_done), 0);
    chk("t_late_stall", 32'(t_stall), 0);
    next_cycle();
    t_rvalid = 1'b0; t_err = 1'b0;
    @(negedge clk);
    chk("t_late_done2", 32'(t_done), 0);
    chk("t_late_fault", 32'(t_fault_bus), 0);
    chk("t_late_raw", t_wb_raw_load, 0);
    next_cycle();
    do_reset();

    // reset while waiting for the response
    req_valid = 1'b1; req_op = MEM_SW; req_addr = 32'h0000_0604; req_wdata = 32'hA1B2_C3D4;
    next_cycle();
    mem_gnt = 1'b1;
    next_cycle();
    mem_gnt = 1'b0;
    @(negedge clk);
    chk("pre_rst_stall", 32'(stall), 1);
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0; req_valid = 1'b0; req_op = MEM_NOP; req_wdata = 32'h0; req_addr = 32'h0;
    @(negedge clk);
    chk_all_zero("rst_wait");
    next_cycle();

    // randomized accesses against the model
    for (int n = 0; n < 40; n++) begin
      mem_op_t     op;
      logic [31:0] addr, wd, rdat;
      int          gd, rd;
      logic        err;
      op   = mem_op_t'(4'($urandom_range(0, 8)));
      addr = $urandom;
      if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
      wd   = $urandom;
      rdat = $urandom;
      gd   = $urandom_range(0, 3);
      rd   = $urandom_range(0, 3);
      err  = ($urandom_range(0, 5) == 0);
      run_access(op, addr, wd, gd, rd, rdat, err, m_be(op, addr), m_wd(op, wd), m_mis(op, addr));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
